inst_fetch_unit: RTL and testbench



---
 rtl/inst_fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding word
// reads to instruction memory, buffers responses with their PCs in a small
// FIFO and hands them to decode over valid/ready. Branch redirects flush all
// buffered and in-flight instructions.
module inst_fetch_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
);

  localparam int unsigned       PTR_W   = $clog2(BUF_DEPTH);
  localparam int unsigned       CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  // DROP means one flushed request is still in flight and its data must be
  // swallowed before a new request can go out.
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DROP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] issued_pc_q, issued_pc_d;

  logic [31:0]       instr_mem_q [BUF_DEPTH];
  logic [ADDR_W-1:0] pc_mem_q    [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  count_after_push;

  logic push, pop, flush;
  logic unused_redirect_lsbs;

  // Target low bits are forced to zero, so they never reach any logic.
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign instr_valid_o    = (count_q != '0);
  assign pop              = instr_valid_o & instr_ready_i;
  // Occupancy once the arriving word is in, accounting for a same-cycle pop.
  assign count_after_push = count_q + CNT_W'(1) - CNT_W'(pop);

  assign imem_req_o  = (state_q == ST_REQ);
  assign imem_addr_o = fetch_pc_q;
  assign instr_o     = instr_mem_q[rd_ptr_q];
  assign pc_o        = pc_mem_q[rd_ptr_q];
  assign pc_plus4_o  = pc_o + PC_STEP;

  // Next-state logic; a redirect overrides every other event this cycle.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    push        = 1'b0;
    flush       = 1'b0;
    if (redirect_i) begin
      flush      = 1'b1;
      fetch_pc_d = {redirect_pc_i[ADDR_W-1:2], 2'b00};
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        // A granted request is now in flight and its data is stale.
        ST_REQ:  state_d = imem_gnt_i ? ST_DROP : ST_REQ;
        // If the pending response lands now it is simply discarded.
        ST_WAIT, ST_DROP: state_d = imem_rvalid_i ? ST_REQ : ST_DROP;
        default: state_d = ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Nothing outstanding here, so only buffered words consume credit.
          if (count_q < DEPTH_C) state_d = ST_REQ;
        end
        ST_REQ: begin
          if (imem_gnt_i) begin
            issued_pc_d = fetch_pc_q;
            fetch_pc_d  = fetch_pc_q + PC_STEP;
            state_d     = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid_i) begin
            push    = 1'b1;
            state_d = (count_after_push < DEPTH_C) ? ST_REQ : ST_IDLE;
          end
        end
        ST_DROP: begin
          if (imem_rvalid_i) state_d = ST_REQ;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FIFO occupancy; a flush empties it even if a pop happens alongside.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Fetch state and PC registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
    end
  end

  // Instruction buffer storage and pointers; entries clear on reset so the
  // head reads as instruction 0 at PC 0 until the first push.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          instr_mem_q[wr_ptr_q] <= imem_rdata_i;
          pc_mem_q[wr_ptr_q]    <= issued_pc_q;
          wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed vector table, hand-written corner
// sequences (redirect with pop and rvalid, PC wrap, async reset mid-WAIT)
// and randomized traffic checked against a queue-based reference model.
module tb_inst_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  inst_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000),
    .BUF_DEPTH(DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .pc_plus4_o   (pc_plus4_o),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory contents: a distinct word for every address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_9617;
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_opc;
  bit          m_out;
  bit          m_stale;
  int          n_deliv;

  // Pre-edge snapshot of the interface.
  bit          s_req, s_gnt, s_rv, s_ready, s_redir;
  logic [31:0] s_addr, s_rpc;

  logic [31:0] pend_addr;

  task automatic model_reset();
    mq.delete();
    m_pc    = 32'h0;
    m_opc   = 32'h0;
    m_out   = 1'b0;
    m_stale = 1'b0;
    s_req   = 1'b0;
  endtask

  task automatic model_update();
    bit g, r;
    ent_t e;
    g = s_req && s_gnt;
    r = s_rv && m_out;
    if ((mq.size() != 0) && s_ready) begin
      e = mq.pop_front();
      n_deliv++;
      $display("deliver #%0d pc=%h instr=%h", n_deliv, e.pc, e.instr);
    end
    if (g) chk("gnt_addr", s_addr, m_pc);
    if (s_redir) begin
      mq.delete();
      if (g) begin
        m_out   = 1'b1;
        m_stale = 1'b1;
      end else if (r) begin
        m_out   = 1'b0;
        m_stale = 1'b0;
      end else if (m_out) begin
        m_stale = 1'b1;
      end
      m_pc = {s_rpc[31:2], 2'b00};
    end else begin
      if (r) begin
        m_out = 1'b0;
        if (!m_stale) mq.push_back('{instr: mem_word(m_opc), pc: m_opc});
        m_stale = 1'b0;
      end
      if (g) begin
        m_opc   = m_pc;
        m_out   = 1'b1;
        m_stale = 1'b0;
        m_pc    = m_pc + 32'd4;
      end
    end
  endtask

  task automatic model_check();
    chk("mdl_valid", {31'b0, instr_valid_o}, {31'b0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("mdl_instr", instr_o, mq[0].instr);
      chk("mdl_pc", pc_o, mq[0].pc);
      chk("mdl_pc4", pc_plus4_o, mq[0].pc + 32'd4);
    end
    if (imem_req_o) begin
      chk("mdl_credit", {31'b0, (!m_out && (mq.size() < DEPTH))}, 32'd1);
      if (s_req && !s_gnt && !s_redir) chk("mdl_addr_hold", imem_addr_o, s_addr);
    end
  endtask

  task automatic drive(input bit g, input bit r, input bit rd, input bit rdr,
                       input logic [31:0] rpc);
    if (g) pend_addr = imem_addr_o;
    imem_gnt_i    = g;
    imem_rvalid_i = r;
    imem_rdata_i  = mem_word(pend_addr);
    instr_ready_i = rd;
    redirect_i    = rdr;
    redirect_pc_i = rpc;
  endtask

  task automatic step();
    s_req   = imem_req_o;
    s_addr  = imem_addr_o;
    s_gnt   = imem_gnt_i;
    s_rv    = imem_rvalid_i;
    s_ready = instr_ready_i;
    s_redir = redirect_i;
    s_rpc   = redirect_pc_i;
    @(posedge clk);
    if (rst) model_reset();
    else model_update();
    #1;
    if (!rst) model_check();
  endtask

  task automatic cyc(input bit g, input bit r, input bit rd, input bit rdr,
                     input logic [31:0] rpc);
    drive(g, r, rd, rdr, rpc);
    step();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req_o}, 32'd0);
    chk({tag, "_addr"}, imem_addr_o, 32'h0);
    chk({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd0);
    chk({tag, "_instr"}, instr_o, 32'h0);
    chk({tag, "_pc"}, pc_o, 32'h0);
    chk({tag, "_pc4"}, pc_plus4_o, 32'h4);
  endtask

  task automatic chk_out(input string tag, input bit e_req, input logic [31:0] e_addr,
                         input bit e_valid, input logic [31:0] e_pc);
    chk({tag, "_req"}, {31'b0, imem_req_o}, {31'b0, e_req});
    if (e_req) chk({tag, "_addr"}, imem_addr_o, e_addr);
    chk({tag, "_valid"}, {31'b0, instr_valid_o}, {31'b0, e_valid});
    if (e_valid) begin
      chk({tag, "_pc"}, pc_o, e_pc);
      chk({tag, "_instr"}, instr_o, mem_word(e_pc));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          gnt, rv, ready, redir;
    logic [31:0] rpc;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit          pend;
    bit          g, r;
    logic [31:0] rpc;

    n_deliv   = 0;
    pend_addr = 32'h0;
    rst       = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 32'h0);
    step();
    step();
    chk_reset_values("reset");
    rst = 1'b0;

    // fetch stream, stall with full buffer, redirect with outstanding request
    tbl.push_back('{0,0,1,0,32'h0,   1,32'h0,  0,32'h0});
    tbl.push_back('{1,0,1,0,32'h0,   0,32'h0,  0,32'h0});
    tbl.push_back('{0,1,1,0,32'h0,   1,32'h4,  1,32'h0});
    tbl.push_back('{1,0,1,0,32'h0,   0,32'h0,  0,32'h0});
    tbl.push_back('{0,1,1,0,32'h0,   1,32'h8,  1,32'h4});
    tbl.push_back('{1,0,1,0,32'h0,   0,32'h0,  0,32'h0});
    tbl.push_back('{0,1,1,0,32'h0,   1,32'hC,  1,32'h8});
    tbl.push_back('{1,0,0,0,32'h0,   0,32'h0,  1,32'h8});
    tbl.push_back('{0,1,0,0,32'h0,   0,32'h0,  1,32'h8});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{0,0,0,0,32'h0, 0,32'h0,  1,32'h8});
    tbl.push_back('{0,0,1,0,32'h0,   0,32'h0,  1,32'hC});
    tbl.push_back('{0,0,0,0,32'h0,   1,32'h10, 1,32'hC});
    tbl.push_back('{1,0,1,0,32'h0,   0,32'h0,  0,32'h0});
    tbl.push_back('{0,0,0,1,32'h103, 0,32'h0,  0,32'h0});
    tbl.push_back('{0,1,0,0,32'h0,   1,32'h100,0,32'h0});
    tbl.push_back('{1,0,0,0,32'h0,   0,32'h0,  0,32'h0});
    tbl.push_back('{0,1,0,0,32'h0,   1,32'h104,1,32'h100});

    foreach (tbl[i]) begin
      cyc(tbl[i].gnt, tbl[i].rv, tbl[i].ready, tbl[i].redir, tbl[i].rpc);
      $display("row %0d: req=%0b addr=%h valid=%0b pc=%h", i, imem_req_o, imem_addr_o,
               instr_valid_o, pc_o);
      chk_out($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_pc);
    end

    // redirect coinciding with rvalid and a pop, then PC wrap-around
    cyc(1, 0, 0, 0, 32'h0);
    chk_out("a_wait", 0, 32'h0, 1, 32'h100);
    cyc(0, 1, 1, 1, 32'hFFFF_FFFA);
    chk_out("a_redir", 1, 32'hFFFF_FFF8, 0, 32'h0);
    cyc(1, 0, 0, 0, 32'h0);
    cyc(0, 1, 0, 0, 32'h0);
    chk_out("a_wrap1", 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8);
    cyc(1, 0, 0, 0, 32'h0);
    cyc(0, 1, 0, 0, 32'h0);
    chk_out("a_full", 0, 32'h0, 1, 32'hFFFF_FFF8);
    cyc(0, 0, 1, 0, 32'h0);
    chk_out("a_head", 0, 32'h0, 1, 32'hFFFF_FFFC);
    chk("a_pc4_wrap", pc_plus4_o, 32'h0);
    cyc(0, 0, 1, 0, 32'h0);
    chk_out("a_refetch", 1, 32'h0, 0, 32'h0);

    // asynchronous reset mid-WAIT with one buffered entry, then a late rvalid
    cyc(1, 0, 0, 0, 32'h0);
    cyc(0, 1, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 32'h0);
    chk_out("b_wait", 0, 32'h0, 1, 32'h0);
    drive(0, 0, 0, 0, 32'h0);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk_reset_values("b_async");
    step();
    rst = 1'b0;
    cyc(0, 1, 1, 0, 32'h0);
    chk_out("b_late_rv", 1, 32'h0, 0, 32'h0);
    cyc(0, 0, 1, 0, 32'h0);
    chk_out("b_restart", 1, 32'h0, 0, 32'h0);

    // randomized traffic against the reference model
    pend = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      g   = imem_req_o && ($urandom_range(0, 9) < 7);
      r   = pend && ($urandom_range(0, 9) < 6);
      rpc = $urandom();
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      cyc(g, r, 1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0), rpc);
      if (r) pend = 1'b0;
      if (g) pend = 1'b1;
    end

    drive(0, 0, 0, 0, 32'h0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
